// File: rtl/fx_dot_accum.sv
// Streaming fixed-point accumulator: sums each group of signed products into one
// saturated dot-product term, presented through a single-entry output register.
module fx_dot_accum #(
   parameter int WIDTH     = 32,
   parameter int QFRAC     = 16,
   parameter int MAX_TERMS = 16,
   parameter int GUARD     = 8,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             out_err
);
   localparam int ACC_W = WIDTH + GUARD;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   // The guard bits must hold MAX_TERMS full-scale products without wrapping.
   generate
      if (GUARD < $clog2(MAX_TERMS) || QFRAC >= WIDTH) begin : g_bad_params
         $error("fx_dot_accum: GUARD too small for MAX_TERMS or QFRAC >= WIDTH");
      end
   endgenerate

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_sat;
   logic             r_out_err;

   logic             w_accept;
   logic             w_xfer;
   logic [ACC_W-1:0] w_sum_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_close;
   logic [GUARD:0]   w_sum_hi;
   logic             w_sat;
   logic [WIDTH-1:0] w_clamped;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_xfer     = r_out_valid && out_ready;
   assign w_sum_next = r_acc + {{GUARD{in_data[WIDTH-1]}}, in_data};
   assign w_cnt_next = r_cnt + 1'b1;
   assign w_close    = in_last || (w_cnt_next == MAX_CNT);

   // The sum fits WIDTH bits only when all bits above the WIDTH sign bit agree with it.
   assign w_sum_hi  = w_sum_next[ACC_W-1:WIDTH-1];
   assign w_sat     = !((&w_sum_hi) || !(|w_sum_hi));
   assign w_clamped = !w_sat ? w_sum_next[WIDTH-1:0] :
                      w_sum_next[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                            {1'b0, {(WIDTH-1){1'b1}}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
         r_out_sat   <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_close) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_clamped;
               r_out_count <= w_cnt_next;
               r_out_sat   <= w_sat;
               r_out_err   <= !in_last;
               r_acc       <= '0;
               r_cnt       <= '0;
            end else begin
               r_acc <= w_sum_next;
               r_cnt <= w_cnt_next;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_count = r_out_count;
   assign out_sat   = r_out_sat;
   assign out_err   = r_out_err;
endmodule

// File: tb/tb_fx_dot_accum.sv
// Bench for fx_dot_accum: vector table, hand-written backpressure/reset sequences,
// and a randomized run checked against a group-level reference model.
module tb_fx_dot_accum;
   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;
   logic             out_err;

   fx_dot_accum #(.WIDTH(32), .QFRAC(16), .MAX_TERMS(16), .GUARD(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_sat(out_sat), .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic        ev;
      logic [31:0] ed;
      logic [4:0]  ec;
      logic        es;
      logic        ee;
   } vec_t;

   vec_t tbl[28];
   int   n_cmp = 0;
   int   n_err = 0;

   // Values seen at the start of the most recent cycle, before its active edge.
   logic        s_in_ready;
   logic        s_out_valid;
   logic [38:0] s_out_rec;

   logic [38:0] exp_q[$];
   longint      grp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample, cross the rising edge.
   task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      #1;
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_out_rec   = {out_data, out_count, out_sat, out_err};
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input int i, input logic [31:0] d, input logic l, input logic ev,
                      input logic [31:0] ed, input logic [4:0] ec, input logic es, input logic ee);
      tbl[i].d = d;  tbl[i].l = l;  tbl[i].ev = ev; tbl[i].ed = ed;
      tbl[i].ec = ec; tbl[i].es = es; tbl[i].ee = ee;
   endtask

   // Reference: a group is a list of beats; its result is the clamped plain sum.
   function automatic logic [38:0] group_result(input logic last);
      longint s = 0;
      logic [31:0] d;
      logic sat;
      foreach (grp_q[k]) s += grp_q[k];
      sat = 1'b0;
      if (s > 64'sd2147483647) begin
         d = 32'h7FFFFFFF; sat = 1'b1;
      end else if (s < -64'sd2147483648) begin
         d = 32'h80000000; sat = 1'b1;
      end else begin
         d = s[31:0];
      end
      return {d, 5'(grp_q.size()), sat, !last};
   endfunction

   initial begin
      logic [31:0] rd;
      logic        rv, rl, rr;
      logic [38:0] e;

      put(0, 32'h00010000, 0, 0, 0, 0, 0, 0);
      put(1, 32'h00020000, 0, 0, 0, 0, 0, 0);
      put(2, 32'hFFFF8000, 0, 0, 0, 0, 0, 0);
      put(3, 32'h00004000, 1, 1, 32'h0002C000, 4, 0, 0);
      put(4, 32'h7FFF0000, 0, 0, 0, 0, 0, 0);
      put(5, 32'h00020000, 1, 1, 32'h7FFFFFFF, 2, 1, 0);
      put(6, 32'h80000000, 0, 0, 0, 0, 0, 0);
      put(7, 32'hFFFF0000, 1, 1, 32'h80000000, 2, 1, 0);
      for (int i = 8; i < 23; i++) put(i, 32'h00010000, 0, 0, 0, 0, 0, 0);
      put(23, 32'h00010000, 0, 1, 32'h00100000, 16, 0, 1);
      put(24, 32'h00010000, 1, 1, 32'h00010000, 1, 0, 0);
      put(25, 32'h00000005, 1, 1, 32'h00000005, 1, 0, 0);
      put(26, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1, 0, 0);
      put(27, 32'h80000000, 1, 1, 32'h80000000, 1, 0, 0);

      rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
      @(negedge clk);
      chk("reset_out", {out_valid, out_data, out_count, out_sat, out_err}, 39'd0);
      chk("reset_in_ready", in_ready, 1);
      rst = 1'b0;

      // Table: out_ready held high, one beat per cycle.
      for (int i = 0; i < 28; i++) begin
         cyc(1, tbl[i].d, tbl[i].l, 1);
         chk($sformatf("tbl%0d_in_ready", i), s_in_ready, 1);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         if (tbl[i].ev)
            chk($sformatf("tbl%0d_result", i), {out_data, out_count, out_sat, out_err},
                {tbl[i].ed, tbl[i].ec, tbl[i].es, tbl[i].ee});
      end
      cyc(0, 0, 0, 1);
      chk("drain_valid", out_valid, 0);

      // Backpressure: A held, B offered but refused until out_ready rises.
      cyc(1, 32'h00010000, 1, 0);
      chk("bp_a_accept", s_in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 32'h00030000, 1, 0);
         chk("bp_in_ready", s_in_ready, 0);
         chk("bp_hold", {s_out_valid, s_out_rec}, {1'b1, 32'h00010000, 5'd1, 1'b0, 1'b0});
      end
      cyc(1, 32'h00030000, 1, 1);
      chk("bp_a_xfer", {s_in_ready, s_out_valid, s_out_rec},
          {2'b11, 32'h00010000, 5'd1, 1'b0, 1'b0});
      chk("bp_b_result", {out_valid, out_data, out_count}, {1'b1, 32'h00030000, 5'd1});
      cyc(0, 0, 0, 1);
      chk("bp_b_once", out_valid, 0);

      // Asynchronous reset clears a held result without a clock edge.
      cyc(1, 32'h00090000, 1, 0);
      #2 rst = 1'b1;
      #1 chk("rst_async_out", {out_valid, out_data, out_count, out_sat, out_err}, 39'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-group discards the partial sum of group C.
      cyc(1, 32'h00070000, 0, 1);
      cyc(1, 32'h00070000, 0, 1);
      #2 rst = 1'b1;
      #1 chk("rst_mid_out", {out_valid, out_data}, 33'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 32'h00050000, 1, 1);
      chk("rst_after", {out_valid, out_data, out_count, out_sat, out_err},
          {1'b1, 32'h00050000, 5'd1, 1'b0, 1'b0});
      cyc(0, 0, 0, 1);

      // Randomized traffic against the group-level model.
      for (int n = 0; n < 600; n++) begin
         rv = ($urandom_range(9) < 7);
         rl = ($urandom_range(9) < 2);
         rr = ($urandom_range(9) < 7);
         case ($urandom_range(3))
            0: rd = $urandom;
            1: rd = 32'h7FFF0000 + $urandom_range(65535);
            2: rd = 32'h80000000 + $urandom_range(65535);
            default: rd = $urandom_range(32'h20000) - 32'h10000;
         endcase
         if (n >= 590) begin rv = 0; rr = 1; end
         cyc(rv, rd, rl, rr);
         chk("rnd_in_ready", s_in_ready, (exp_q.size() == 0) || rr);
         chk("rnd_out_valid", s_out_valid, exp_q.size() != 0);
         if (s_out_valid && rr && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rnd_result", s_out_rec, e);
         end
         if (rv && s_in_ready) begin
            grp_q.push_back(longint'($signed(rd)));
            if (rl || grp_q.size() == 16) begin
               exp_q.push_back(group_result(rl));
               grp_q.delete();
            end
         end
      end
      chk("rnd_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
